// File: rtl/instr_issue_buffer_if.sv
// Purpose: bundles the instruction-memory read port, the pre-decoder
// handshake and the issue-history / PC-enable outputs of the issue buffer.
// Ports (as seen by the buffer through the slave modport):
//   in : imem_data, imem_data2, pd_pc_en, pd_instr_sel, pd_store_instr,
//        pd_out_instr, branch_flush
//   out: instr, instr2, last_instr, last3_instr, pc_en, buf_state
interface instr_issue_buffer_if #(
  parameter int unsigned ISIZE = 16
);
  logic [ISIZE-1:0] imem_data;
  logic [ISIZE-1:0] imem_data2;
  logic             pd_pc_en;
  logic             pd_instr_sel;
  logic [ISIZE-1:0] pd_store_instr;
  logic [ISIZE-1:0] pd_out_instr;
  logic             branch_flush;
  logic [ISIZE-1:0] instr;
  logic [ISIZE-1:0] instr2;
  logic [ISIZE-1:0] last_instr;
  logic [ISIZE-1:0] last3_instr;
  logic             pc_en;
  logic [1:0]       buf_state;

  // Environment side: memory plus pre-decoder.
  modport master (
    output imem_data, imem_data2, pd_pc_en, pd_instr_sel, pd_store_instr,
           pd_out_instr, branch_flush,
    input  instr, instr2, last_instr, last3_instr, pc_en, buf_state
  );

  // Issue buffer side.
  modport slave (
    input  imem_data, imem_data2, pd_pc_en, pd_instr_sel, pd_store_instr,
           pd_out_instr, branch_flush,
    output instr, instr2, last_instr, last3_instr, pc_en, buf_state
  );
endinterface

// File: rtl/instr_issue_buffer.sv
// Purpose: fetch-side issue buffer feeding the pre-decoder. Presents the
// instruction pair, keeps a hold register for stalls and for replaying the
// older word displaced by a lw/sw reorder, tracks the issue history and
// gates the PC enable.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - instr_issue_buffer_if.slave (memory words, pre-decoder decisions,
//          branch flush in; instr/instr2, history, pc_en, buf_state out)
module instr_issue_buffer #(
  parameter int unsigned      ISIZE     = 16,
  parameter logic [ISIZE-1:0] STALL_NOP = ISIZE'(16'h7000),
  parameter logic [ISIZE-1:0] BUBBLE    = ISIZE'(16'h0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_issue_buffer_if.slave   bus
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    STALL   = 2'd1,
    SWAPPED = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ISIZE-1:0] hold;
  logic [ISIZE-1:0] hold_next;
  logic [ISIZE-1:0] h1;
  logic [ISIZE-1:0] h2;
  logic [ISIZE-1:0] h3;
  logic [ISIZE-1:0] h1_next;
  logic [ISIZE-1:0] instr_mux;
  logic [ISIZE-1:0] instr2_mux;
  logic             swap;
  logic             illegal_sel;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Swap: pre-decoder issued the lookahead word ahead of the current one.
  // The inequality keeps identical adjacent words from looking like a swap.
  assign swap = bus.pd_pc_en
              & (bus.pd_out_instr == instr2_mux)
              & (bus.pd_out_instr != instr_mux)
              & (state != SWAPPED);

  // Next state and hold-register update, flush has top priority.
  always_comb begin
    state_next = NORMAL;
    hold_next  = hold;
    if (bus.branch_flush) begin
      state_next = NORMAL;
      hold_next  = BUBBLE;
    end else if (!bus.pd_pc_en) begin
      hold_next  = bus.pd_store_instr;
      state_next = (state == SWAPPED) ? SWAPPED : STALL;
    end else if (swap) begin
      hold_next  = bus.pd_store_instr;
      state_next = SWAPPED;
    end else begin
      state_next = NORMAL;
    end
  end

  // Output mux driven by the current state.
  always_comb begin
    instr_mux  = bus.imem_data;
    instr2_mux = bus.imem_data2;
    case (state)
      STALL: begin
        instr_mux  = hold;
        instr2_mux = bus.imem_data2;
      end
      SWAPPED: begin
        instr_mux  = hold;
        instr2_mux = BUBBLE;
      end
      default: begin
        instr_mux  = bus.imem_data;
        instr2_mux = bus.imem_data2;
      end
    endcase
  end

  // Stalled or flushed slots enter the history as the stall NOP.
  assign h1_next = (bus.branch_flush || !bus.pd_pc_en) ? STALL_NOP : bus.pd_out_instr;

  // Hold register and issue history chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= BUBBLE;
      h1   <= STALL_NOP;
      h2   <= STALL_NOP;
      h3   <= STALL_NOP;
    end else begin
      hold <= hold_next;
      h1   <= h1_next;
      h2   <= h1;
      h3   <= h2;
    end
  end

  assign bus.instr       = instr_mux;
  assign bus.instr2      = instr2_mux;
  assign bus.last_instr  = h1;
  assign bus.last3_instr = h3;
  assign bus.pc_en       = bus.pd_pc_en & ~bus.branch_flush;
  assign bus.buf_state   = state;

  // Replay request while the PC is enabled is a pre-decoder protocol error.
  assign illegal_sel = bus.pd_instr_sel & bus.pd_pc_en;

  illegal_sel_chk : assert property (@(posedge clk) disable iff (rst) !illegal_sel)
    else $error("instr_issue_buffer: instr_sel asserted with PC_En");

endmodule

// File: tb/tb_instr_issue_buffer.sv
module tb_instr_issue_buffer;
  localparam int unsigned ISIZE = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  instr_issue_buffer_if #(.ISIZE(ISIZE)) bus ();

  instr_issue_buffer #(.ISIZE(ISIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [15:0] d2, input logic en,
                       input logic [15:0] outw, input logic [15:0] store, input logic flush);
    bus.imem_data      = d;
    bus.imem_data2     = d2;
    bus.pd_pc_en       = en;
    bus.pd_out_instr   = outw;
    bus.pd_store_instr = store;
    bus.branch_flush   = flush;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.pd_instr_sel = 1'b0;
    drive(16'h1123, 16'h2456, 1'b1, 16'h1123, 16'h0000, 1'b0);
    #10;
    chk("rst_instr",  bus.instr, 16'h1123);
    chk("rst_instr2", bus.instr2, 16'h2456);
    chk("rst_pc_en",  16'(bus.pc_en), 16'h0001);
    chk("rst_state",  16'(bus.buf_state), 16'h0000);
    chk("rst_last",   bus.last_instr, 16'h7000);
    chk("rst_last3",  bus.last3_instr, 16'h7000);
    rst = 1'b0;
    tick();
    chk("run_last",  bus.last_instr, 16'h1123);
    chk("run_last3", bus.last3_instr, 16'h7000);
    chk("run_state", 16'(bus.buf_state), 16'h0000);

    // Stall, then release.
    drive(16'h1123, 16'h2456, 1'b0, 16'h0000, 16'h1123, 1'b0);
    chk("stall_pc_en", 16'(bus.pc_en), 16'h0000);
    tick();
    chk("stall_state", 16'(bus.buf_state), 16'h0001);
    chk("stall_instr", bus.instr, 16'h1123);
    chk("stall_last",  bus.last_instr, 16'h7000);
    drive(16'h1123, 16'h2456, 1'b1, 16'h1123, 16'h0000, 1'b0);
    tick();
    chk("rel_state", 16'(bus.buf_state), 16'h0000);
    chk("rel_last",  bus.last_instr, 16'h1123);
    chk("rel_last3", bus.last3_instr, 16'h1123);

    // Swap, then replay.
    drive(16'h0123, 16'h8450, 1'b1, 16'h8450, 16'h0123, 1'b0);
    chk("swap_pc_en", 16'(bus.pc_en), 16'h0001);
    tick();
    chk("swap_state",  16'(bus.buf_state), 16'h0002);
    chk("swap_instr",  bus.instr, 16'h0123);
    chk("swap_instr2", bus.instr2, 16'h0000);
    chk("swap_last",   bus.last_instr, 16'h8450);
    chk("swap_last3",  bus.last3_instr, 16'h7000);
    drive(16'h8450, 16'h9999, 1'b1, 16'h0123, 16'h0000, 1'b0);
    tick();
    bus.imem_data  = 16'h9999;
    bus.imem_data2 = 16'haaaa;
    #1;
    chk("replay_state", 16'(bus.buf_state), 16'h0000);
    chk("replay_instr", bus.instr, 16'h9999);
    chk("replay_last",  bus.last_instr, 16'h0123);
    chk("replay_last3", bus.last3_instr, 16'h1123);

    // Stall while swapped.
    drive(16'h0123, 16'h8450, 1'b1, 16'h8450, 16'h0123, 1'b0);
    tick();
    drive(16'h8450, 16'h9999, 1'b0, 16'h0000, 16'h0123, 1'b0);
    chk("sws_pc_en", 16'(bus.pc_en), 16'h0000);
    tick();
    chk("sws_state",  16'(bus.buf_state), 16'h0002);
    chk("sws_instr",  bus.instr, 16'h0123);
    chk("sws_instr2", bus.instr2, 16'h0000);
    chk("sws_last",   bus.last_instr, 16'h7000);
    chk("sws_last3",  bus.last3_instr, 16'h0123);

    // Leave SWAPPED, stall, then flush during STALL.
    drive(16'h8450, 16'h9999, 1'b1, 16'h0123, 16'h0000, 1'b0);
    tick();
    drive(16'h5555, 16'h6666, 1'b0, 16'h0000, 16'h5555, 1'b0);
    tick();
    chk("fl_pre_state", 16'(bus.buf_state), 16'h0001);
    chk("fl_pre_instr", bus.instr, 16'h5555);
    drive(16'h7777, 16'h1234, 1'b1, 16'h5555, 16'h0000, 1'b1);
    chk("fl_pc_en", 16'(bus.pc_en), 16'h0000);
    tick();
    bus.branch_flush = 1'b0;
    #1;
    chk("fl_state", 16'(bus.buf_state), 16'h0000);
    chk("fl_last",  bus.last_instr, 16'h7000);
    chk("fl_last3", bus.last3_instr, 16'h0123);
    chk("fl_instr", bus.instr, 16'h7777);

    // Identical adjacent words must not swap.
    drive(16'h4444, 16'h4444, 1'b1, 16'h4444, 16'h0000, 1'b0);
    tick();
    chk("same_state", 16'(bus.buf_state), 16'h0000);
    chk("same_last",  bus.last_instr, 16'h4444);

    // Flush coinciding with a swap wins.
    drive(16'h0123, 16'h8450, 1'b1, 16'h8450, 16'h0123, 1'b1);
    tick();
    chk("flsw_state", 16'(bus.buf_state), 16'h0000);
    chk("flsw_last",  bus.last_instr, 16'h7000);

    // Asynchronous reset in the middle of SWAPPED.
    drive(16'h0123, 16'h8450, 1'b1, 16'h8450, 16'h0123, 1'b0);
    tick();
    chk("ar_pre_state", 16'(bus.buf_state), 16'h0002);
    drive(16'h8450, 16'h9999, 1'b1, 16'h0123, 16'h0000, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_state", 16'(bus.buf_state), 16'h0000);
    chk("ar_last",  bus.last_instr, 16'h7000);
    chk("ar_last3", bus.last3_instr, 16'h7000);
    chk("ar_instr", bus.instr, 16'h8450);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_issue_buffer.md
Name: instr_issue_buffer

Overview:
- Fetch-side partner of the pre-decoder: produces the instruction pair (Instr/Instr2) and the issue history (LastInstr/Last3Instr) the pre-decoder consumes.
- Absorbs its decisions (PC_En, instr_sel, storeInstr, outInstr): hold register for stalls, replay of the displaced older instruction after a lw/sw reorder, and PC enable to the PC unit.
- Sits between instruction memory (two-word read port at PC, PC+1) and the pre-decoder.

Parameters:
ISIZE, 16, instruction width in bits
STALL_NOP, 16'h7000, word recorded in history for a stalled issue slot and used as reset/flush history value
BUBBLE, 16'h0000, word presented on instr2 while replaying a swapped instruction (its opcode is not lw/sw, so it is never reordered)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_data  input  ISIZE  instruction memory word at PC
imem_data2  input  ISIZE  instruction memory word at PC+1
pd_pc_en  input  1  PC_En from pre-decoder
pd_instr_sel  input  1  instr_sel from pre-decoder (1 = replay hold register)
pd_store_instr  input  ISIZE  storeInstr from pre-decoder
pd_out_instr  input  ISIZE  outInstr from pre-decoder (word actually issued to decode)
branch_flush  input  1  taken branch/jump resolved; discard buffered state
instr  output  ISIZE  Instr to pre-decoder
instr2  output  ISIZE  Instr2 (lookahead) to pre-decoder
last_instr  output  ISIZE  word issued 1 cycle ago
last3_instr  output  ISIZE  word issued 3 cycles ago
pc_en  output  1  PC increment enable to PC unit
buf_state  output  2  debug: 0 NORMAL, 1 STALL, 2 SWAPPED

Behaviour:
- State register (NORMAL/STALL/SWAPPED), hold register hold[ISIZE], history shift chain h1,h2,h3.
- Reset (async): state=NORMAL, hold=BUBBLE, h1=h2=h3=STALL_NOP. After reset: instr=imem_data, instr2=imem_data2, last_instr=last3_instr=STALL_NOP, pc_en follows pd_pc_en.
- Output mux (combinational from state):
  - NORMAL: instr=imem_data, instr2=imem_data2.
  - STALL: instr=hold, instr2=imem_data2.
  - SWAPPED: instr=hold, instr2=BUBBLE.
- pc_en = pd_pc_en & ~branch_flush. PC advances by exactly 1 per enabled cycle in all states.
- Swap detect (comb): swap = pd_pc_en & (pd_out_instr == instr2) & (pd_out_instr != instr) & (state != SWAPPED).
- Next state, priority high to low:
  - branch_flush: NORMAL; hold=BUBBLE.
  - pd_pc_en==0 (stall): hold <= pd_store_instr. Next state is STALL from NORMAL or STALL; stays SWAPPED from SWAPPED.
  - swap: hold <= pd_store_instr (the displaced older word); next SWAPPED. One cycle later the PC has moved onto the already-issued younger word; it is replaced by hold and imem_data2 gives the correct lookahead.
  - otherwise: NORMAL; hold unchanged.
- pd_instr_sel==1 with pd_pc_en==1 is illegal. Checker flags it; state follows pd_pc_en.
- History, every cycle:
  - h1 <= branch_flush ? STALL_NOP : (pd_pc_en ? pd_out_instr : STALL_NOP); h2 <= h1; h3 <= h2.
  - last_instr=h1, last3_instr=h3.
- Latency: a stalled or displaced instruction reappears on instr exactly 1 cycle after capture. A stall while in SWAPPED keeps hold and SWAPPED until an enabled cycle.
- Boundaries:
  - Back-to-back stalls: hold re-captures each cycle. The pre-decoder returns the same word, so the value is stable.
  - Flush coinciding with stall or swap: flush wins, hold discarded.
  - Reset mid-SWAPPED: displaced instruction is lost by design.
  - instr==instr2 with no swap: swap must not assert (the inequality term guarantees this).

Test Plan:
- Reset, imem_data=16'h1123, imem_data2=16'h2456, pd_pc_en=1, pd_out_instr=16'h1123 -> instr=16'h1123, pc_en=1, state NORMAL; next cycle last_instr=16'h1123, last3_instr=16'h7000.
- Stall: pd_pc_en=0, pd_store_instr=16'h1123 -> pc_en=0, next cycle state STALL, instr=16'h1123, last_instr=16'h7000; release pd_pc_en=1 -> NORMAL next cycle.
- Swap: instr=16'h0123, instr2=16'h8450, pd_out_instr=16'h8450, pd_store_instr=16'h0123 -> next cycle SWAPPED, instr=16'h0123, instr2=16'h0000, last_instr=16'h8450; following cycle NORMAL with instr=imem_data.
- Stall while SWAPPED (pd_pc_en=0) -> stays SWAPPED, instr=16'h0123, pc_en=0, last_instr=16'h7000.
- branch_flush during STALL -> pc_en=0, next cycle NORMAL, last_instr=16'h7000, instr=imem_data.
- Assert rst asynchronously mid-cycle in SWAPPED -> immediately NORMAL, last_instr=last3_instr=16'h7000, no wait for clk edge.
